// File: rtl/neuron_step_scheduler.sv
// Time-multiplexes one shared Q3.12 neuron-update datapath across N_NEURONS neurons.
// Holds per-neuron v/w/current, sweeps neurons in index order, and emits threshold-crossing spikes.
module neuron_step_scheduler #(
    parameter int             N_NEURONS = 8,
    parameter int             IDX_W     = 3,
    parameter int             W         = 16,
    parameter logic [W-1:0]   V_INIT    = 16'hECE1,
    parameter logic [W-1:0]   W_INIT    = 16'hF600,
    parameter logic [W-1:0]   SPIKE_TH  = 16'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [15:0]      step_count,
    input  logic             cur_we,
    input  logic [IDX_W-1:0] cur_addr,
    input  logic [W-1:0]     cur_data,
    output logic             dp_req,
    output logic [IDX_W-1:0] dp_idx,
    output logic [W-1:0]     dp_v,
    output logic [W-1:0]     dp_w,
    output logic [W-1:0]     dp_i,
    input  logic             dp_ack,
    input  logic [W-1:0]     dp_v_next,
    input  logic [W-1:0]     dp_w_next,
    output logic             spk_valid,
    output logic [IDX_W-1:0] spk_idx,
    input  logic             spk_ready,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_v,
    output logic [W-1:0]     rd_w
);

    // Handshakes: dp_req/dp_ack transfer when both are high at a rising edge, and the
    // operands are held stable until then; spk_valid/spk_ready likewise, with spk_idx held.
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WB, S_SPIKE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     v_mem_q [N_NEURONS];
    logic [W-1:0]     w_mem_q [N_NEURONS];
    logic [W-1:0]     i_mem_q [N_NEURONS];
    logic [W-1:0]     dp_v_q, dp_w_q, dp_i_q;
    logic [W-1:0]     vn_q, wn_q;
    logic [15:0]      step_q;

    logic load, capture, wb_en, last, spike;

    assign last  = (idx_q == IDX_W'(N_NEURONS - 1));
    // dp_v_q still holds the pre-update v of the neuron being written back.
    assign spike = ($signed(dp_v_q) < $signed(SPIKE_TH)) && ($signed(vn_q) >= $signed(SPIKE_TH));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        capture = 1'b0;
        wb_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (dp_ack) begin
                    capture = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wb_en = 1'b1;
                if (spike) begin
                    state_d = S_SPIKE;
                end else if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    idx_d   = idx_q + IDX_W'(1);
                    load    = 1'b1;
                end
            end
            S_SPIKE: begin
                if (spk_ready) begin
                    if (last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        idx_d   = idx_q + IDX_W'(1);
                        load    = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dp_v_q  <= '0;
            dp_w_q  <= '0;
            dp_i_q  <= '0;
            vn_q    <= '0;
            wn_q    <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                dp_v_q <= v_mem_q[idx_d];
                dp_w_q <= w_mem_q[idx_d];
                dp_i_q <= i_mem_q[idx_d];
            end
            if (capture) begin
                vn_q <= dp_v_next;
                wn_q <= dp_w_next;
            end
            if (state_q == S_DONE) begin
                step_q <= step_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem_q[n] <= V_INIT;
                w_mem_q[n] <= W_INIT;
                i_mem_q[n] <= '0;
            end
        end else begin
            if (wb_en) begin
                v_mem_q[idx_q] <= vn_q;
                w_mem_q[idx_q] <= wn_q;
            end
            if (cur_we && (int'(cur_addr) < N_NEURONS)) begin
                i_mem_q[cur_addr] <= cur_data;
            end
        end
    end

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WB) || (state_q == S_SPIKE);
    assign done       = (state_q == S_DONE);
    assign step_count = step_q;
    assign dp_req     = (state_q == S_ISSUE);
    assign dp_idx     = idx_q;
    assign dp_v       = dp_v_q;
    assign dp_w       = dp_w_q;
    assign dp_i       = dp_i_q;
    assign spk_valid  = (state_q == S_SPIKE);
    assign spk_idx    = idx_q;
    assign rd_v       = (int'(rd_idx) < N_NEURONS) ? v_mem_q[rd_idx] : '0;
    assign rd_w       = (int'(rd_idx) < N_NEURONS) ? w_mem_q[rd_idx] : '0;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Bench for neuron_step_scheduler: directed sweeps plus randomized currents/ack/ready,
// checked against an array-level model of the sweep.
module tb_neuron_step_scheduler;

    localparam int          N      = 8;
    localparam logic [15:0] V_INIT = 16'hECE1;
    localparam logic [15:0] W_INIT = 16'hF600;
    localparam logic [15:0] TH     = 16'h1000;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] step_count;
    logic        cur_we = 1'b0;
    logic [2:0]  cur_addr = '0;
    logic [15:0] cur_data = '0;
    logic        dp_req;
    logic [2:0]  dp_idx;
    logic [15:0] dp_v, dp_w, dp_i;
    logic        dp_ack = 1'b1;
    logic [15:0] dp_v_next, dp_w_next;
    logic        spk_valid;
    logic [2:0]  spk_idx;
    logic        spk_ready = 1'b1;
    logic [2:0]  rd_idx = '0;
    logic [15:0] rd_v, rd_w;

    neuron_step_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .step_count(step_count), .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
        .dp_req(dp_req), .dp_idx(dp_idx), .dp_v(dp_v), .dp_w(dp_w), .dp_i(dp_i),
        .dp_ack(dp_ack), .dp_v_next(dp_v_next), .dp_w_next(dp_w_next),
        .spk_valid(spk_valid), .spk_idx(spk_idx), .spk_ready(spk_ready),
        .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w)
    );

    // datapath stub knobs
    logic [15:0] v_inc = 16'd1;
    logic [15:0] w_inc = 16'd0;
    int          spk_tgt = -1;
    logic [15:0] spk_val = '0;
    int          ack_mode = 0;     // 0 tied high, 1 delay 3 cycles on ack_idx, 2 random
    int          ack_idx = -1;
    int          ack_wait = 0;
    int          rdy_mode = 0;     // 0 tied high, 1 manual, 2 random
    logic        rdy_manual = 1'b1;

    always @* begin
        dp_v_next = (int'(dp_idx) == spk_tgt) ? spk_val : dp_v + v_inc;
        dp_w_next = dp_w + w_inc;
    end

    // reference model + scoreboard
    logic [15:0] v_m [N];
    logic [15:0] w_m [N];
    logic [15:0] i_m [N];
    logic [15:0] exp_q[$];         // expected spike indices, in order
    int          exp_idx = 0;
    int          n_sweeps = 0;
    int          spikes_seen = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    bit          in_issue = 0;
    logic [15:0] snap_v, snap_w, snap_i;
    logic [2:0]  snap_idx;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            v_m[i] = V_INIT;
            w_m[i] = W_INIT;
            i_m[i] = '0;
        end
        exp_q.delete();
        exp_idx  = 0;
        n_sweeps = 0;
    endtask

    // Responder drives ack/ready, then the monitor samples what the DUT will see next edge.
    always @(negedge clk) begin
        case (ack_mode)
            0: dp_ack = 1'b1;
            1: begin
                if (dp_req && int'(dp_idx) == ack_idx && ack_wait < 3) begin
                    dp_ack = 1'b0;
                    ack_wait++;
                end else begin
                    dp_ack = 1'b1;
                end
            end
            default: dp_ack = ($urandom_range(0, 2) != 0);
        endcase
        case (rdy_mode)
            0:       spk_ready = 1'b1;
            1:       spk_ready = rdy_manual;
            default: spk_ready = ($urandom_range(0, 2) == 0);
        endcase

        if (rst) begin
            in_issue = 0;
        end else begin
            if (dp_req) begin
                if (!in_issue) begin
                    in_issue = 1;
                    snap_idx = dp_idx; snap_v = dp_v; snap_w = dp_w; snap_i = dp_i;
                    check("issue_idx", dp_idx, exp_idx);
                    check("issue_v", dp_v, v_m[exp_idx & 7]);
                    check("issue_w", dp_w, w_m[exp_idx & 7]);
                    check("issue_i", dp_i, i_m[exp_idx & 7]);
                    check("spike_not_emitted", exp_q.size(), 0);
                end else begin
                    check("hold_idx", dp_idx, snap_idx);
                    check("hold_v", dp_v, snap_v);
                    check("hold_w", dp_w, snap_w);
                    check("hold_i", dp_i, snap_i);
                end
                if (dp_ack) begin
                    int k;
                    logic [15:0] old_v, nv;
                    k     = exp_idx & 7;
                    old_v = v_m[k];
                    nv    = (k == spk_tgt) ? spk_val : old_v + v_inc;
                    v_m[k] = nv;
                    w_m[k] = w_m[k] + w_inc;
                    if ($signed(old_v) < $signed(TH) && $signed(nv) >= $signed(TH))
                        exp_q.push_back(16'(k));
                    exp_idx++;
                    in_issue = 0;
                end
            end
            if (spk_valid) begin
                check("spk_idx", spk_idx, (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'hFFFF);
                check("no_req_while_spike", dp_req, 0);
                if (spk_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    spikes_seen++;
                end
            end
        end
    end

    // driver tasks
    task automatic write_cur(int a, logic [15:0] d);
        cur_we   = 1'b1;
        cur_addr = 3'(a);
        cur_data = d;
        @(posedge clk);
        i_m[a] = d;
        #1 cur_we = 1'b0;
    endtask

    task automatic check_rd();
        for (int i = 0; i < N; i++) begin
            rd_idx = 3'(i);
            #1;
            check("rd_v", rd_v, v_m[i]);
            check("rd_w", rd_w, w_m[i]);
        end
    endtask

    task automatic run_sweep(int exp_lat);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 0;
        @(posedge clk); #1;
        exp_idx = 0;
        start   = 1'b1;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1);
            end
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("sweep_done_seen", seen, 1);
        if (exp_lat > 0) check("sweep_latency", cyc, exp_lat);
        n_sweeps++;
        check("busy_low_in_done", busy, 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("step_count", step_count, n_sweeps & 16'hFFFF);
        check("sweep_len", exp_idx, N);
        check("spikes_drained", exp_q.size(), 0);
        check_rd();
    endtask

    initial begin
        int sp0;
        bit found;
        model_reset();

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_dp_req", dp_req, 0);
        check("rst_spk_valid", spk_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_done", done, 0);
        check("rst_step", step_count, 0);
        check("rst_dp_idx", dp_idx, 0);
        check("rst_spk_idx", spk_idx, 0);
        check_rd();

        // 2. zero-wait sweep
        run_sweep(17);

        // 3. 3-cycle ack delay on idx 2
        ack_mode = 1; ack_idx = 2; ack_wait = 0;
        run_sweep(20);
        ack_mode = 0;

        // 4. spike with backpressure, then no re-fire above threshold
        sp0 = spikes_seen;
        spk_tgt = 5; spk_val = 16'h1000;
        rdy_mode = 1; rdy_manual = 1'b0;
        fork
            run_sweep(0);
            begin
                found = 0;
                for (int c = 0; c < 200 && !found; c++) begin
                    @(posedge clk); #1;
                    if (spk_valid) found = 1;
                end
                check("spike_seen", found, 1);
                for (int c = 0; c < 4 && found; c++) begin
                    check("stall_valid", spk_valid, 1);
                    check("stall_idx", spk_idx, 5);
                    check("stall_no_req", dp_req, 0);
                    @(posedge clk); #1;
                end
                rdy_manual = 1'b1;
            end
        join
        check("one_spike", spikes_seen - sp0, 1);
        rdy_mode = 0;
        spk_val = 16'h1100;
        run_sweep(0);
        check("no_refire", spikes_seen - sp0, 1);
        spk_tgt = -1;

        // 5. current writes mid-sweep and ignored start
        @(posedge clk); #1;
        write_cur(3, 16'h0100);
        fork
            run_sweep(17);
            begin
                found = 0;
                for (int c = 0; c < 100 && !found; c++) begin
                    @(posedge clk); #1;
                    if (dp_req && dp_idx == 3'd3) found = 1;
                end
                check("reach_idx3", found, 1);
                check("dp_i_before_write", dp_i, 16'h0100);
                write_cur(3, 16'h0800);
                write_cur(6, 16'h0123);
                found = 0;
                for (int c = 0; c < 100 && !found; c++) begin
                    @(posedge clk); #1;
                    if (dp_req && dp_idx == 3'd5) found = 1;
                end
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("start_ignored_busy", busy, 0);
        check("start_ignored_step", step_count, n_sweeps);
        run_sweep(17);

        // randomized sweeps: currents, increments, ack and ready
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) write_cur(i, 16'($urandom));
            v_inc = 16'($urandom_range(0, 16'h1800));
            w_inc = 16'($urandom);
            ack_mode = 2;
            rdy_mode = 2;
            run_sweep(0);
        end
        ack_mode = 0; rdy_mode = 0; v_inc = 16'd1; w_inc = 16'd0;

        // 6. reset mid-sweep at idx 4
        @(posedge clk); #1;
        exp_idx = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (dp_req && dp_idx == 3'd4) found = 1;
            else begin @(posedge clk); #1; end
        end
        check("reach_idx4", found, 1);
        rst = 1'b1;
        #1;
        check("abort_dp_req", dp_req, 0);
        check("abort_busy", busy, 0);
        check("abort_spk_valid", spk_valid, 0);
        check("abort_done", done, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_step", step_count, 0);
        check_rd();
        run_sweep(17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
